// File: rtl/inst_buffer_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer_reader_pkg
// Description : Shared constants for the decoded-instruction buffer reader:
//               dispatch width, decoded packet width and field offsets,
//               branch checkpoint count and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_buffer_reader_pkg;

    localparam int DISPATCH_WIDTH = 4;

    // Decoded packet width, identical to the instruction buffer's packet width
    localparam int PKT_W = 64;

    // Decoded packet field layout (LSB offsets and widths)
    localparam int PKT_PC_LSB     = 0;
    localparam int PKT_PC_W       = 32;
    localparam int PKT_OPC_LSB    = 32;
    localparam int PKT_OPC_W      = 8;
    localparam int PKT_DEST_LSB   = 40;
    localparam int PKT_DEST_W     = 6;
    localparam int PKT_SRC1_LSB   = 46;
    localparam int PKT_SRC1_W     = 6;
    localparam int PKT_SRC2_LSB   = 52;
    localparam int PKT_SRC2_W     = 6;
    localparam int PKT_CTI_BIT    = 63;  // packet is a control-transfer instruction

    // Branch checkpoints
    localparam int BRANCH_TAGS = 8;
    localparam int TAG_W       = $clog2(BRANCH_TAGS + 1);
    localparam int BRC_W       = 3;     // branch count per group, 0..4

endpackage : inst_buffer_reader_pkg
`default_nettype wire

// File: rtl/inst_buffer_reader_tag_counter.sv
`default_nettype none
// ============================================================================
// Module      : branch_tag_counter
// Description : Free branch-checkpoint counter. Debits the branches of an
//               accepted group, credits checkpoints released by branch
//               resolution, clamps at BRANCH_TAGS and reloads the post-recovery
//               count on flush.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               flush            - load recover_free (priority over all else)
//               recover_free     - free count after recovery
//               debit            - branches consumed this cycle (0 if no accept)
//               credit           - checkpoints released this cycle (0..2)
//               free_tags        - registered free-checkpoint count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_tag_counter #(
    parameter int BRANCH_TAGS = inst_buffer_reader_pkg::BRANCH_TAGS,
    parameter int TAG_W       = inst_buffer_reader_pkg::TAG_W,
    parameter int BRC_W       = inst_buffer_reader_pkg::BRC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [TAG_W-1:0] recover_free,
    input  logic [BRC_W-1:0] debit,
    input  logic [1:0]       credit,
    output logic [TAG_W-1:0] free_tags
);

    // One extra bit so that a credit past BRANCH_TAGS is visible before clamping
    localparam int CW = TAG_W + 1;
    localparam logic [CW-1:0] MAX_TAGS = CW'(BRANCH_TAGS);

    logic [TAG_W-1:0] count;
    logic [CW-1:0]    sum;
    logic [TAG_W-1:0] count_next;

    // The debit never exceeds the count: a group is only accepted when its
    // branch count fits in the registered free count.
    assign sum        = CW'(count) - CW'(debit) + CW'(credit);
    assign count_next = (sum > MAX_TAGS) ? TAG_W'(BRANCH_TAGS) : sum[TAG_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= TAG_W'(BRANCH_TAGS);
        end else if (flush) begin
            count <= recover_free;
        end else begin
            count <= count_next;
        end
    end

`ifndef SYNTHESIS
    // Releasing more checkpoints than exist means the resolution logic and
    // this counter disagree about what is outstanding.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (sum <= MAX_TAGS)
                else $error("branch_tag_counter: free count overflow (%0d > %0d)", sum, BRANCH_TAGS);
        end
    end
`endif

    assign free_tags = count;

endmodule : branch_tag_counter
`default_nettype wire

// File: rtl/inst_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer_reader
// Description : Consumer stage of the decoded-instruction buffer. Takes one
//               4-wide dispatch group per cycle into a one-entry register that
//               feeds rename, tracks free branch checkpoints and drives the
//               buffer's stall when rename is blocked or the group's branches
//               cannot be covered.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               flush_i               - pipeline flush (discard group, recover tags)
//               bufReady_i            - buffer head holds 4 valid packets
//               pkt0_i..pkt3_i        - head packets, oldest in pkt0
//               branchCount_i         - CTI packets in the head group
//               renameStall_i         - rename cannot take the held group
//               brFree_i              - checkpoints released this cycle
//               recoverFree_i         - free count after recovery (on flush)
//               bufStall_o            - buffer stall (combinational)
//               groupValid_o          - register holds a group
//               pkt0_o..pkt3_o        - registered group
//               groupBranches_o       - registered branch count
//               freeTags_o            - free-checkpoint count
//               groupSeq_o            - sequence number of the held group
// Revision    : 1.0 - initial release
// ============================================================================
module inst_buffer_reader #(
    parameter int PKT_W       = inst_buffer_reader_pkg::PKT_W,
    parameter int BRANCH_TAGS = inst_buffer_reader_pkg::BRANCH_TAGS,
    parameter int TAG_W       = inst_buffer_reader_pkg::TAG_W,
    parameter int BRC_W       = inst_buffer_reader_pkg::BRC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             bufReady_i,
    input  logic [PKT_W-1:0] pkt0_i,
    input  logic [PKT_W-1:0] pkt1_i,
    input  logic [PKT_W-1:0] pkt2_i,
    input  logic [PKT_W-1:0] pkt3_i,
    input  logic [BRC_W-1:0] branchCount_i,
    input  logic             renameStall_i,
    input  logic [1:0]       brFree_i,
    input  logic [TAG_W-1:0] recoverFree_i,
    output logic             bufStall_o,
    output logic             groupValid_o,
    output logic [PKT_W-1:0] pkt0_o,
    output logic [PKT_W-1:0] pkt1_o,
    output logic [PKT_W-1:0] pkt2_o,
    output logic [PKT_W-1:0] pkt3_o,
    output logic [BRC_W-1:0] groupBranches_o,
    output logic [TAG_W-1:0] freeTags_o,
    output logic [7:0]       groupSeq_o
);

    import inst_buffer_reader_pkg::*;

    if (BRANCH_TAGS < DISPATCH_WIDTH) begin : g_param_check
        $error("inst_buffer_reader: BRANCH_TAGS must be at least DISPATCH_WIDTH");
    end

    logic             group_valid;
    logic [PKT_W-1:0] pkt0;
    logic [PKT_W-1:0] pkt1;
    logic [PKT_W-1:0] pkt2;
    logic [PKT_W-1:0] pkt3;
    logic [BRC_W-1:0] group_branches;
    logic [7:0]       group_seq;
    logic [TAG_W-1:0] free_tags;

    logic             drain;
    logic             can_take;
    logic             tag_ok;
    logic             stall;
    logic             accept;
    logic [BRC_W-1:0] debit;

    assign drain    = group_valid & ~renameStall_i;
    assign can_take = ~group_valid | ~renameStall_i;
    // Only the registered count is trusted; this cycle's releases are ignored
    // so the check never depends on resolution timing.
    assign tag_ok   = TAG_W'(branchCount_i) <= free_tags;
    // The buffer advances whenever it is not stalled, so every cycle in which
    // a group is not taken must assert stall, including reset and flush.
    assign stall    = reset | flush_i | ~can_take | ~tag_ok;
    assign accept   = bufReady_i & ~stall;
    assign debit    = accept ? branchCount_i : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            group_valid    <= 1'b0;
            pkt0           <= '0;
            pkt1           <= '0;
            pkt2           <= '0;
            pkt3           <= '0;
            group_branches <= '0;
            group_seq      <= '0;
        end else if (flush_i) begin
            // Sequence number is kept so group IDs stay monotonic across flushes
            group_valid <= 1'b0;
        end else if (accept) begin
            group_valid    <= 1'b1;
            pkt0           <= pkt0_i;
            pkt1           <= pkt1_i;
            pkt2           <= pkt2_i;
            pkt3           <= pkt3_i;
            group_branches <= branchCount_i;
            group_seq      <= group_seq + 8'd1;
        end else if (drain) begin
            group_valid <= 1'b0;
        end
    end

    branch_tag_counter #(
        .BRANCH_TAGS (BRANCH_TAGS),
        .TAG_W       (TAG_W),
        .BRC_W       (BRC_W)
    ) u_tag_counter (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush_i),
        .recover_free (recoverFree_i),
        .debit        (debit),
        .credit       (brFree_i),
        .free_tags    (free_tags)
    );

    assign bufStall_o      = stall;
    assign groupValid_o    = group_valid;
    assign pkt0_o          = pkt0;
    assign pkt1_o          = pkt1;
    assign pkt2_o          = pkt2;
    assign pkt3_o          = pkt3;
    assign groupBranches_o = group_branches;
    assign freeTags_o      = free_tags;
    assign groupSeq_o      = group_seq;

endmodule : inst_buffer_reader
`default_nettype wire

// File: tb/tb_inst_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_buffer_reader
// Description : Directed self-checking bench for inst_buffer_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_buffer_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        bufReady_i;
    logic [63:0] pkt0_i, pkt1_i, pkt2_i, pkt3_i;
    logic [2:0]  branchCount_i;
    logic        renameStall_i;
    logic [1:0]  brFree_i;
    logic [3:0]  recoverFree_i;
    logic        bufStall_o;
    logic        groupValid_o;
    logic [63:0] pkt0_o, pkt1_o, pkt2_o, pkt3_o;
    logic [2:0]  groupBranches_o;
    logic [3:0]  freeTags_o;
    logic [7:0]  groupSeq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_buffer_reader dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .bufReady_i      (bufReady_i),
        .pkt0_i          (pkt0_i),
        .pkt1_i          (pkt1_i),
        .pkt2_i          (pkt2_i),
        .pkt3_i          (pkt3_i),
        .branchCount_i   (branchCount_i),
        .renameStall_i   (renameStall_i),
        .brFree_i        (brFree_i),
        .recoverFree_i   (recoverFree_i),
        .bufStall_o      (bufStall_o),
        .groupValid_o    (groupValid_o),
        .pkt0_o          (pkt0_o),
        .pkt1_o          (pkt1_o),
        .pkt2_o          (pkt2_o),
        .pkt3_o          (pkt3_o),
        .groupBranches_o (groupBranches_o),
        .freeTags_o      (freeTags_o),
        .groupSeq_o      (groupSeq_o)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_group(input logic [63:0] base);
        pkt0_i = base + 64'd0;
        pkt1_i = base + 64'd1;
        pkt2_i = base + 64'd2;
        pkt3_i = base + 64'd3;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush_i = 1'b0; bufReady_i = 1'b1; renameStall_i = 1'b0;
        branchCount_i = 3'd0; brFree_i = 2'd0; recoverFree_i = 4'd0;
        drive_group(64'hDEAD_0000_0000_0000);
        #1;
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", bufStall_o); end
        step(); step();
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_held got=%b exp=1", bufStall_o); end
        checks++; if (groupValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", groupValid_o); end
        checks++; if (freeTags_o !== 4'd8) begin errors++; $display("FAIL reset_tags got=%0d exp=8", freeTags_o); end
        checks++; if (groupSeq_o !== 8'd0) begin errors++; $display("FAIL reset_seq got=%0d exp=0", groupSeq_o); end
        checks++; if ({pkt0_o, pkt1_o, pkt2_o, pkt3_o} !== 256'd0) begin errors++; $display("FAIL reset_pkts got=%h exp=0", pkt0_o); end
        checks++; if (groupBranches_o !== 3'd0) begin errors++; $display("FAIL reset_branches got=%0d exp=0", groupBranches_o); end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        bufReady_i = 1'b1; branchCount_i = 3'd1; brFree_i = 2'd1; renameStall_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_group(64'hA000_0000_0000_0000 + 64'(i * 16));
            #1;
            checks++; if (bufStall_o !== 1'b0) begin errors++; $display("FAIL stream_stall[%0d] got=%b exp=0", i, bufStall_o); end
            step();
            checks++; if (groupValid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, groupValid_o); end
            checks++; if (groupSeq_o !== 8'(i)) begin errors++; $display("FAIL stream_seq[%0d] got=%0d exp=%0d", i, groupSeq_o, i); end
            checks++; if (freeTags_o !== 4'd8) begin errors++; $display("FAIL stream_tags[%0d] got=%0d exp=8", i, freeTags_o); end
            checks++; if (pkt0_o !== 64'hA000_0000_0000_0000 + 64'(i * 16) ||
                          pkt3_o !== 64'hA000_0000_0000_0003 + 64'(i * 16)) begin
                errors++; $display("FAIL stream_pkt[%0d] got=%h/%h exp=%h/%h", i, pkt0_o, pkt3_o,
                                   64'hA000_0000_0000_0000 + 64'(i * 16), 64'hA000_0000_0000_0003 + 64'(i * 16));
            end
            checks++; if (groupBranches_o !== 3'd1) begin errors++; $display("FAIL stream_branches[%0d] got=%0d exp=1", i, groupBranches_o); end
        end
    endtask

    // Group seq 4 (pkt0 = A..40) is held; next group waits behind rename.
    task automatic test_backpressure();
        renameStall_i = 1'b1; brFree_i = 2'd0; branchCount_i = 3'd1;
        drive_group(64'hB000_0000_0000_0000);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL bp_stall[%0d] got=%b exp=1", c, bufStall_o); end
            step();
            checks++; if (pkt0_o !== 64'hA000_0000_0000_0040 || groupSeq_o !== 8'd4 || groupValid_o !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got=%h seq=%0d v=%b exp=a000000000000040 seq=4 v=1", c, pkt0_o, groupSeq_o, groupValid_o);
            end
        end
        renameStall_i = 1'b0;
        #1;
        checks++; if (bufStall_o !== 1'b0) begin errors++; $display("FAIL bp_release_stall got=%b exp=0", bufStall_o); end
        step();
        checks++; if (pkt0_o !== 64'hB000_0000_0000_0000 || groupSeq_o !== 8'd5 || groupValid_o !== 1'b1) begin
            errors++; $display("FAIL bp_release_load got=%h seq=%0d v=%b exp=b000000000000000 seq=5 v=1", pkt0_o, groupSeq_o, groupValid_o);
        end
        checks++; if (freeTags_o !== 4'd7) begin errors++; $display("FAIL bp_tags got=%0d exp=7", freeTags_o); end
        // Drain with one release: back to 8 free and an empty register
        bufReady_i = 1'b0; brFree_i = 2'd1;
        step();
        checks++; if (groupValid_o !== 1'b0 || freeTags_o !== 4'd8) begin
            errors++; $display("FAIL bp_drain got=v%b tags=%0d exp=v0 tags=8", groupValid_o, freeTags_o);
        end
    endtask

    task automatic test_tag_exhaustion();
        bufReady_i = 1'b1; brFree_i = 2'd0; branchCount_i = 3'd4;
        drive_group(64'hC000_0000_0000_0000);
        step();
        checks++; if (freeTags_o !== 4'd4 || groupSeq_o !== 8'd6) begin errors++; $display("FAIL tag_first got=tags%0d seq%0d exp=tags4 seq6", freeTags_o, groupSeq_o); end
        drive_group(64'hC000_0000_0000_0010);
        step();
        checks++; if (freeTags_o !== 4'd0 || groupSeq_o !== 8'd7) begin errors++; $display("FAIL tag_second got=tags%0d seq%0d exp=tags0 seq7", freeTags_o, groupSeq_o); end
        branchCount_i = 3'd1;
        drive_group(64'hC000_0000_0000_0020);
        #1;
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL tag_block got=%b exp=1", bufStall_o); end
        step();
        checks++; if (groupSeq_o !== 8'd7 || groupValid_o !== 1'b0) begin errors++; $display("FAIL tag_no_accept got=seq%0d v%b exp=seq7 v0", groupSeq_o, groupValid_o); end
        // Releases this cycle do not unblock until registered
        brFree_i = 2'd2;
        #1;
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL tag_conservative got=%b exp=1", bufStall_o); end
        step();
        checks++; if (freeTags_o !== 4'd2 || groupSeq_o !== 8'd7) begin errors++; $display("FAIL tag_credit got=tags%0d seq%0d exp=tags2 seq7", freeTags_o, groupSeq_o); end
        brFree_i = 2'd0;
        #1;
        checks++; if (bufStall_o !== 1'b0) begin errors++; $display("FAIL tag_unblock got=%b exp=0", bufStall_o); end
        step();
        checks++; if (freeTags_o !== 4'd1 || groupSeq_o !== 8'd8 || pkt0_o !== 64'hC000_0000_0000_0020) begin
            errors++; $display("FAIL tag_accept got=tags%0d seq%0d pkt%h exp=tags1 seq8 pkt c000000000000020", freeTags_o, groupSeq_o, pkt0_o);
        end
    endtask

    task automatic test_zero_branch();
        branchCount_i = 3'd1;
        drive_group(64'hD000_0000_0000_0000);
        step();
        checks++; if (freeTags_o !== 4'd0 || groupSeq_o !== 8'd9) begin errors++; $display("FAIL zb_setup got=tags%0d seq%0d exp=tags0 seq9", freeTags_o, groupSeq_o); end
        branchCount_i = 3'd0;
        drive_group(64'hD000_0000_0000_0010);
        #1;
        checks++; if (bufStall_o !== 1'b0) begin errors++; $display("FAIL zb_stall got=%b exp=0", bufStall_o); end
        step();
        checks++; if (freeTags_o !== 4'd0 || groupSeq_o !== 8'd10 || groupBranches_o !== 3'd0) begin
            errors++; $display("FAIL zb_accept got=tags%0d seq%0d br%0d exp=tags0 seq10 br0", freeTags_o, groupSeq_o, groupBranches_o);
        end
    endtask

    task automatic test_flush();
        bufReady_i = 1'b0; brFree_i = 2'd2;
        step();
        bufReady_i = 1'b1; brFree_i = 2'd0; branchCount_i = 3'd0;
        drive_group(64'hE000_0000_0000_0000);
        step();
        checks++; if (groupValid_o !== 1'b1 || freeTags_o !== 4'd2 || groupSeq_o !== 8'd11) begin
            errors++; $display("FAIL flush_setup got=v%b tags%0d seq%0d exp=v1 tags2 seq11", groupValid_o, freeTags_o, groupSeq_o);
        end
        flush_i = 1'b1; recoverFree_i = 4'd6; brFree_i = 2'd2;
        drive_group(64'hE000_0000_0000_0010);
        #1;
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b exp=1", bufStall_o); end
        step();
        checks++; if (groupValid_o !== 1'b0 || freeTags_o !== 4'd6 || groupSeq_o !== 8'd11) begin
            errors++; $display("FAIL flush_result got=v%b tags%0d seq%0d exp=v0 tags6 seq11", groupValid_o, freeTags_o, groupSeq_o);
        end
        flush_i = 1'b0; brFree_i = 2'd0; recoverFree_i = 4'd0;
        #1;
        checks++; if (bufStall_o !== 1'b0) begin errors++; $display("FAIL flush_after_stall got=%b exp=0", bufStall_o); end
    endtask

    task automatic test_seq_wrap();
        bufReady_i = 1'b1; branchCount_i = 3'd0;
        for (int i = 12; i <= 255; i++) step();
        checks++; if (groupSeq_o !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d exp=255", groupSeq_o); end
        step();
        checks++; if (groupSeq_o !== 8'd0 || groupValid_o !== 1'b1) begin errors++; $display("FAIL wrap_0 got=seq%0d v%b exp=seq0 v1", groupSeq_o, groupValid_o); end
    endtask

    task automatic test_reset_midstream();
        bufReady_i = 1'b1; branchCount_i = 3'd2; brFree_i = 2'd0;
        drive_group(64'hF000_0000_0000_0000);
        step();
        checks++; if (freeTags_o !== 4'd4 || groupSeq_o !== 8'd1) begin errors++; $display("FAIL rst_mid_setup got=tags%0d seq%0d exp=tags4 seq1", freeTags_o, groupSeq_o); end
        reset = 1'b1;
        #1;
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL rst_mid_stall got=%b exp=1", bufStall_o); end
        step();
        checks++; if (groupValid_o !== 1'b0 || freeTags_o !== 4'd8 || groupSeq_o !== 8'd0 ||
                      pkt0_o !== 64'd0 || groupBranches_o !== 3'd0) begin
            errors++; $display("FAIL rst_mid_values got=v%b tags%0d seq%0d pkt%h br%0d exp=v0 tags8 seq0 pkt0 br0",
                               groupValid_o, freeTags_o, groupSeq_o, pkt0_o, groupBranches_o);
        end
        checks++; if (bufStall_o !== 1'b1) begin errors++; $display("FAIL rst_mid_stall_held got=%b exp=1", bufStall_o); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_tag_exhaustion();
        test_zero_branch();
        test_flush();
        test_seq_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_inst_buffer_reader
`default_nettype wire

// File: doc/inst_buffer_reader.md
# inst_buffer_reader

Consumer-side stage for the decoded-instruction buffer. Each cycle it takes one 4-wide dispatch group from the buffer's read head into a one-entry pipeline register that feeds rename. It tracks free branch checkpoints and returns a stall to the buffer when rename is blocked or the group's branches cannot be covered. It sits between the instruction buffer and the rename stage, and is the only driver of the buffer's `stall_i`.

## Interface
Parameters:
- `PKT_W`, 64: decoded packet width, identical to the buffer's packet width.
- `BRANCH_TAGS`, 8: total branch checkpoints; must be at least 4.
- `TAG_W`, 4: counter width, `clog2(BRANCH_TAGS+1)`.
- `BRC_W`, 3: width of the branch-count input (values 0..4).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `flush_i`  in  1  misprediction or exception flush; same cycle the buffer flushes.
- `bufReady_i`  in  1  buffer holds at least 4 valid packets; `pkt*_i` are valid.
- `pkt0_i..pkt3_i`  in  `PKT_W` each  head-of-buffer packets, oldest in `pkt0`.
- `branchCount_i`  in  `BRC_W`  number of CTI packets in the current group.
- `renameStall_i`  in  1  rename cannot take the group now.
- `brFree_i`  in  2  checkpoints released by branch resolution this cycle (0..2).
- `recoverFree_i`  in  `TAG_W`  free-checkpoint count after recovery; sampled on flush.
- `bufStall_o`  out  1  drives the buffer's `stall_i`.
- `groupValid_o`  out  1  the output register holds a group.
- `pkt0_o..pkt3_o`  out  `PKT_W` each  registered group.
- `groupBranches_o`  out  `BRC_W`  registered branch count of the group.
- `freeTags_o`  out  `TAG_W`  current free-checkpoint count.
- `groupSeq_o`  out  8  sequence number of the group held in the register.

## Operation
- `drain = groupValid_o & ~renameStall_i`.
- `canTake = ~groupValid_o | ~renameStall_i`.
- `tagOk = branchCount_i <= freeTags`. The comparison uses the registered count only; this cycle's `brFree_i` is not counted (conservative).
- `bufStall_o = reset | flush_i | ~canTake | ~tagOk`. This is combinational. It must be 1 whenever a group is not consumed, because the buffer advances its head on `~stall_i` whenever it holds 4 or more packets.
- `accept = bufReady_i & ~bufStall_o`.
- Output register update:
  - On `accept`, load `pkt*_i`, `branchCount_i`, and `groupSeq+1`; `groupValid` becomes 1.
  - Else on `drain`, `groupValid` becomes 0 and the data is held (don't-care).
  - Else hold everything.
- Free-tag counter: `freeTags_next = freeTags - (accept ? branchCount_i : 0) + brFree_i`.
  - Compute in `TAG_W+1` bits, then clamp to `BRANCH_TAGS`.
  - Overflow above `BRANCH_TAGS` is a protocol error; raise a simulation-only assertion.
- `groupSeq`: 8-bit counter, increments on every `accept`, wraps 255 -> 0. It is not cleared by `flush_i`, so IDs stay monotonic for debug.
- Flush has priority over accept, drain, and `brFree_i`:
  - `groupValid` goes to 0.
  - `freeTags` loads `recoverFree_i`.
  - `groupSeq` holds.
- Reset values: `groupValid_o=0`, `pkt*_o=0`, `groupBranches_o=0`, `freeTags_o=BRANCH_TAGS`, `groupSeq_o=0`, `bufStall_o=1` while `reset` is high.

## Timing
- Latency is one cycle: a group accepted at edge N appears on `pkt*_o` with `groupValid_o=1` after edge N.
- Back-to-back groups stream at one per cycle while `renameStall_i=0`. Drain and accept in the same cycle replace the register contents with no bubble.
- `freeTags_o` reflects a cycle's `accept` debit and `brFree_i` credit after that edge.
- With `bufReady_i=0`, `bufStall_o` is don't-care to the buffer but must still follow the formula.
- Reset or flush mid-stream: the group in the register is discarded. The first accept can occur the cycle after `flush_i` deasserts.

## Structure
- Shared package holds:
  - `DISPATCH_WIDTH=4`
  - `PKT_W` and the field offsets of the decoded packet, including the CTI bit
  - `BRANCH_TAGS`
  - `TAG_W`
- A natural sub-module is `branch_tag_counter`, which holds the debit, credit, clamp, and recover-load logic. The top level is the group register plus the stall logic.

## Test plan
- Streaming: after reset, `bufReady_i=1`, `branchCount_i=1` every cycle, `brFree_i=1` -> one accept per cycle, `bufStall_o=0`, `freeTags_o` stays at 8, `groupSeq_o` = 1, 2, 3…
- Rename backpressure: group valid, `renameStall_i=1` for 3 cycles -> `bufStall_o=1`, `pkt*_o` held. On release, the same cycle accepts the next group with no bubble.
- Tag exhaustion: free count 8, two groups of 4 branches accepted -> `freeTags_o=0`. A third group with `branchCount_i=1` -> `bufStall_o=1` until `brFree_i=2`, then accept, leaving `freeTags_o=1`.
- Zero-branch group with `freeTags_o=0` -> accepted, counter unchanged.
- Flush: group valid, `freeTags_o=2`, `flush_i=1` with `recoverFree_i=6`, `brFree_i=2` -> `groupValid_o=0`, `freeTags_o=6`, `groupSeq_o` unchanged. Also check `groupSeq` wrap 255 -> 0.
- Reset mid-stream with `bufReady_i=1` -> `bufStall_o=1` during reset, and all outputs return to their reset values.
